// File: rtl/sci_op_scheduler.sv
// Op scheduler: buffers one-hot-mode op packets, dispatches them one at a time to
// the selected compute unit, waits for completion or timeout, and counts drops.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for a queued packet; pops the FIFO head when present
//   ISSUE  | one-cycle start pulse to the selected unit, arm timeout timer
//   WAIT   | operands held; waiting for selected unit_done or timeout
//   RESP   | one-cycle done pulse, data_out already updated
module sci_op_scheduler #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_MODES      = 4,
    parameter int RES_WIDTH      = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pkt_valid,
    input  logic [DATA_WIDTH-1:0]         op_pkt__data,
    input  logic [NUM_MODES-1:0]          op_pkt__mode,
    input  logic [RES_WIDTH-1:0]          op_pkt__res,
    output logic                          ready,
    output logic [NUM_MODES-1:0]          unit_start,
    output logic [DATA_WIDTH-1:0]         unit_data,
    output logic [RES_WIDTH-1:0]          unit_res,
    input  logic [NUM_MODES-1:0]          unit_done,
    input  logic [NUM_MODES*DATA_WIDTH-1:0] unit_result,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          done,
    output logic                          pkt_dropd,
    output logic [7:0]                    drop_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int EW = DATA_WIDTH + NUM_MODES + RES_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          tmr_q, tmr_d;
    logic [DATA_WIDTH-1:0]  hold_data_q, hold_data_d;
    logic [NUM_MODES-1:0]   hold_mode_q, hold_mode_d;
    logic [RES_WIDTH-1:0]   hold_res_q, hold_res_d;
    logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
    logic                   pkt_dropd_q, pkt_dropd_d;
    logic [7:0]             drop_cnt_q, drop_cnt_d;
    logic                   ready_en_q;

    logic [EW-1:0]          mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          count_q;

    logic                   hs, mode_ok, push, pop, in_drop, to_drop;
    logic [EW-1:0]          head;
    logic [DATA_WIDTH-1:0]  sel_result;
    logic [8:0]             drop_sum;

    assign mode_ok = (op_pkt__mode != '0) &&
                     ((op_pkt__mode & (op_pkt__mode - NUM_MODES'(1))) == '0);
    assign ready   = ready_en_q && (count_q < CW'(FIFO_DEPTH));
    assign hs      = pkt_valid && ready;
    assign push    = hs && mode_ok;
    assign in_drop = hs && !mode_ok;
    assign pop     = (state_q == S_IDLE) && (count_q != '0);
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {op_pkt__data, op_pkt__mode, op_pkt__res};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // hold_mode_q is one-hot, so at most one slice is selected
    always_comb begin
        sel_result = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (hold_mode_q[i]) sel_result = unit_result[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        hold_data_d = hold_data_q;
        hold_mode_d = hold_mode_q;
        hold_res_d  = hold_res_q;
        data_out_d  = data_out_q;
        to_drop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    {hold_data_d, hold_mode_d, hold_res_d} = head;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmr_d   = TW'(TIMEOUT_CYCLES - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if ((unit_done & hold_mode_q) != '0) begin
                    data_out_d = sel_result;
                    state_d    = S_RESP;
                end else if (tmr_q == '0) begin
                    to_drop = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Input drop and timeout drop in one cycle share a pulse but both count
    assign drop_sum    = {1'b0, drop_cnt_q} + 9'(in_drop) + 9'(to_drop);
    assign drop_cnt_d  = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    assign pkt_dropd_d = in_drop || to_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            hold_data_q <= '0;
            hold_mode_q <= '0;
            hold_res_q  <= '0;
            data_out_q  <= '0;
            pkt_dropd_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            hold_data_q <= hold_data_d;
            hold_mode_q <= hold_mode_d;
            hold_res_q  <= hold_res_d;
            data_out_q  <= data_out_d;
            pkt_dropd_q <= pkt_dropd_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign unit_start = (state_q == S_ISSUE) ? hold_mode_q : '0;
    assign unit_data  = hold_data_q;
    assign unit_res   = hold_res_q;
    assign done       = (state_q == S_RESP);
    assign data_out   = data_out_q;
    assign pkt_dropd  = pkt_dropd_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_sci_op_scheduler.sv
// Directed bench for sci_op_scheduler: latency, bad-mode drops, backpressure,
// timeout, simultaneous drops, done-vs-timeout, saturation and mid-op reset.
module tb_sci_op_scheduler;
    localparam int DW = 32;
    localparam int NM = 4;
    localparam int RW = 8;
    localparam int FD = 4;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           pkt_valid;
    logic [DW-1:0]  op_pkt__data;
    logic [NM-1:0]  op_pkt__mode;
    logic [RW-1:0]  op_pkt__res;
    logic           ready;
    logic [NM-1:0]  unit_start;
    logic [DW-1:0]  unit_data;
    logic [RW-1:0]  unit_res;
    logic [NM-1:0]  unit_done;
    logic [NM*DW-1:0] unit_result;
    logic [DW-1:0]  data_out;
    logic           done;
    logic           pkt_dropd;
    logic [7:0]     drop_cnt;

    always #5 clk = ~clk;

    sci_op_scheduler #(
        .DATA_WIDTH(DW), .NUM_MODES(NM), .RES_WIDTH(RW),
        .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pkt_valid(pkt_valid),
        .op_pkt__data(op_pkt__data), .op_pkt__mode(op_pkt__mode), .op_pkt__res(op_pkt__res),
        .ready(ready), .unit_start(unit_start), .unit_data(unit_data), .unit_res(unit_res),
        .unit_done(unit_done), .unit_result(unit_result), .data_out(data_out),
        .done(done), .pkt_dropd(pkt_dropd), .drop_cnt(drop_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    int done_seen = 0;
    int drop_seen = 0;
    int start_cnt = 0;
    int start_cyc[$];
    int drop_cyc[$];
    logic [NM-1:0] start_mode[$];

    always @(negedge clk) begin
        if (done) done_seen++;
        if (pkt_dropd) begin
            drop_seen++;
            drop_cyc.push_back(cyc);
        end
        if (unit_start != '0) begin
            start_cnt++;
            start_cyc.push_back(cyc);
            start_mode.push_back(unit_start);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [NM-1:0] m,
                        input logic [RW-1:0] r, output int hs_cyc);
        int n = 0;
        pkt_valid    = 1'b1;
        op_pkt__data = d;
        op_pkt__mode = m;
        op_pkt__res  = r;
        while (!ready && n < 50) begin
            tick();
            n++;
        end
        if (!ready) chk("handshake_wait", 32'(ready), 32'd1);
        hs_cyc = cyc;
        tick();
        pkt_valid = 1'b0;
    endtask

    task automatic clear_logs();
        start_cyc.delete();
        drop_cyc.delete();
        start_mode.delete();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, s0, d0, dn0;
        int hs[6];
        logic [DW-1:0] dsave;

        rst_n        = 1'b0;
        pkt_valid    = 1'b0;
        op_pkt__data = '0;
        op_pkt__mode = '0;
        op_pkt__res  = '0;
        unit_done    = '0;
        unit_result  = {32'h0BAD0003, 32'h0BAD0002, 32'h00001234, 32'h0BAD0000};

        tick();
        tick();
        chk("rst_ready",      32'(ready),      32'd0);
        chk("rst_unit_start", 32'(unit_start), 32'd0);
        chk("rst_done",       32'(done),       32'd0);
        chk("rst_pkt_dropd",  32'(pkt_dropd),  32'd0);
        chk("rst_data_out",   data_out,        32'd0);
        chk("rst_drop_cnt",   32'(drop_cnt),   32'd0);
        chk("rst_unit_data",  unit_data,       32'd0);
        chk("rst_unit_res",   32'(unit_res),   32'd0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", 32'(ready), 32'd1);

        // single op: unit 1 answers two cycles after its start pulse
        send(32'h0000_00AA, 4'b0010, 8'h05, t0);
        chk("single_start_t1", 32'(unit_start), 32'd0);
        tick();
        chk("single_start_t2", 32'(unit_start), 32'h2);
        chk("single_unit_data", unit_data, 32'hAA);
        chk("single_unit_res", 32'(unit_res), 32'h05);
        tick();
        chk("single_start_t3", 32'(unit_start), 32'd0);
        chk("single_done_t3", 32'(done), 32'd0);
        tick();
        unit_done = 4'b0010;
        chk("single_data_held", unit_data, 32'hAA);
        tick();
        unit_done = '0;
        chk("single_done_t5", 32'(done), 32'd1);
        chk("single_data_out", data_out, 32'h1234);
        tick();
        chk("single_done_t6", 32'(done), 32'd0);
        chk("single_no_drop", 32'(drop_seen), 32'd0);

        // two malformed modes back to back
        d0 = drop_seen;
        s0 = start_cnt;
        pkt_valid = 1'b1;
        op_pkt__mode = 4'b0110;
        tick();
        op_pkt__mode = 4'b0000;
        chk("bad1_dropd", 32'(pkt_dropd), 32'd1);
        tick();
        pkt_valid = 1'b0;
        chk("bad2_dropd", 32'(pkt_dropd), 32'd1);
        tick();
        chk("bad_dropd_clear", 32'(pkt_dropd), 32'd0);
        chk("bad_drop_cnt", 32'(drop_cnt), 32'd2);
        chk("bad_drop_pulses", 32'(drop_seen - d0), 32'd2);
        tick();
        tick();
        chk("bad_no_start", 32'(start_cnt - s0), 32'd0);

        // backpressure and timeout: nobody answers
        clear_logs();
        for (int i = 0; i < 5; i++) send(32'h100 + i, 4'(1 << (i % 4)), 8'(i), hs[i]);
        chk("bp_ready_low", 32'(ready), 32'd0);
        chk("bp_consecutive", 32'(hs[4] - hs[0]), 32'd4);
        send(32'h105, 4'b0010, 8'h05, hs[5]);
        chk("bp_sixth_stall", 32'(hs[5] - hs[0]), 32'd12);
        chk("to_data_out_kept", data_out, 32'h1234);
        chk("to_starts_seen", 32'(start_cyc.size() >= 2), 32'd1);
        chk("to_drops_seen", 32'(drop_cyc.size() >= 1), 32'd1);
        if (start_cyc.size() >= 2 && drop_cyc.size() >= 1) begin
            chk("to_first_start", 32'(start_cyc[0] - hs[0]), 32'd2);
            chk("to_drop_delay", 32'(drop_cyc[0] - start_cyc[0]), 32'd9);
            chk("to_next_issue", 32'(start_cyc[1] - start_cyc[0]), 32'd10);
            chk("to_next_mode", 32'(start_mode[1]), 32'h2);
        end
        apply_reset();

        // timeout and malformed handshake on the same edge; wrong-unit done ignored
        dn0 = done_seen;
        send(32'h55, 4'b0100, 8'h07, t0);
        tick();
        chk("sim_start", 32'(unit_start), 32'h4);
        tick();
        tick();
        tick();
        unit_done = 4'b0001;
        tick();
        unit_done = '0;
        for (int i = 0; i < 4; i++) tick();
        pkt_valid = 1'b1;
        op_pkt__mode = 4'b0000;
        tick();
        pkt_valid = 1'b0;
        chk("sim_dropd", 32'(pkt_dropd), 32'd1);
        chk("sim_drop_cnt", 32'(drop_cnt), 32'd2);
        tick();
        chk("sim_dropd_single", 32'(pkt_dropd), 32'd0);
        chk("sim_drop_cnt_hold", 32'(drop_cnt), 32'd2);
        chk("sim_no_done", 32'(done_seen - dn0), 32'd0);
        chk("sim_data_out", data_out, 32'd0);

        // done on the last wait cycle beats the timeout
        unit_result[3*DW +: DW] = 32'hCAFE_0003;
        send(32'h77, 4'b1000, 8'h09, t0);
        tick();
        chk("dw_start", 32'(unit_start), 32'h8);
        for (int i = 0; i < 8; i++) tick();
        unit_done = 4'b1000;
        tick();
        unit_done = '0;
        chk("dw_done", 32'(done), 32'd1);
        chk("dw_data_out", data_out, 32'hCAFE_0003);
        chk("dw_no_dropd", 32'(pkt_dropd), 32'd0);
        tick();
        chk("dw_no_dropd2", 32'(pkt_dropd), 32'd0);
        chk("dw_drop_cnt", 32'(drop_cnt), 32'd2);

        // drop counter saturation
        pkt_valid = 1'b1;
        op_pkt__mode = 4'b0011;
        for (int i = 0; i < 260; i++) tick();
        pkt_valid = 1'b0;
        tick();
        chk("sat_drop_cnt", 32'(drop_cnt), 32'd255);

        // reset while waiting with three packets queued
        dsave = 32'h11;
        send(dsave, 4'b0001, 8'h01, hs[0]);
        send(32'h22, 4'b0010, 8'h02, hs[1]);
        send(32'h33, 4'b0100, 8'h03, hs[2]);
        send(32'h44, 4'b1000, 8'h04, hs[3]);
        chk("mr_in_wait", unit_data, dsave);
        rst_n = 1'b0;
        #1;
        chk("mr_ready",      32'(ready),      32'd0);
        chk("mr_unit_start", 32'(unit_start), 32'd0);
        chk("mr_done",       32'(done),       32'd0);
        chk("mr_pkt_dropd",  32'(pkt_dropd),  32'd0);
        chk("mr_data_out",   data_out,        32'd0);
        chk("mr_drop_cnt",   32'(drop_cnt),   32'd0);
        chk("mr_unit_data",  unit_data,       32'd0);
        chk("mr_unit_res",   32'(unit_res),   32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        s0  = start_cnt;
        dn0 = done_seen;
        unit_done = 4'b0001;
        tick();
        unit_done = '0;
        chk("mr_ready_after", 32'(ready), 32'd1);
        for (int i = 0; i < 5; i++) tick();
        chk("mr_stale_done", 32'(done_seen - dn0), 32'd0);
        chk("mr_fifo_empty", 32'(start_cnt - s0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
